// File: rtl/alu_acc_seq.sv
// Parametrised ALU + 2W-bit accumulator with sequential shift-add multiply.
// Define ALU_ACC_SAT_EN to make op 001 saturate instead of wrap.
module alu_acc_seq #(
  parameter int W = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [W-1:0]   A,
  input  logic [2:0]     op,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] acc
);

  localparam int AW = 2 * W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_acc;
  logic [AW-1:0] r_mcand;
  logic [AW-1:0] r_prod;
  logic [W-1:0]  r_mplier;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic          w_accept;
  logic          w_mul_go;
  logic          w_last;
  logic          w_done_nx;
  logic [W-1:0]  w_b;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_b2;
  logic [AW:0]   w_sum;
  logic [AW-1:0] w_res;
  logic [AW-1:0] w_prod_nx;

  assign w_b       = r_acc[W-1:0];
  assign w_a2      = {{W{1'b0}}, A};
  assign w_b2      = {{W{1'b0}}, w_b};
  assign w_accept  = start && (r_state == S_IDLE);
  assign w_mul_go  = w_accept && (op == 3'b110);
  assign w_last    = (r_cnt == CW'(W - 1));
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_a2};
  assign w_prod_nx = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_done_nx = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_done_nx = w_accept && !w_mul_go;
        if (w_mul_go) begin
          w_next = S_MUL;
        end
      end
      S_MUL: begin
        if (w_last) begin
          w_next    = S_IDLE;
          w_done_nx = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Result of every single-cycle op; multiply is written from the product.
  always_comb begin
    w_res = r_acc;
    unique case (op)
      3'b000: w_res = w_a2 + w_b2;
      3'b001: begin
`ifdef ALU_ACC_SAT_EN
        w_res = w_sum[AW] ? '1 : w_sum[AW-1:0];
`else
        w_res = w_sum[AW-1:0];
`endif
      end
      3'b010: w_res = {A ^ w_b, A | w_b};
      3'b011: begin
        w_res = '0;
        if (|{A, w_b}) begin
          w_res[AW-1] = 1'b1;
          w_res[0]    = 1'b1;
        end
      end
      3'b100: begin
        w_res = '0;
        if (&{A, w_b}) begin
          w_res       = '1;
          w_res[AW-1] = 1'b0;
          w_res[0]    = 1'b0;
        end
      end
      // Shift amounts >= AW push every bit out, giving 0.
      3'b101: w_res = w_b2 << A;
      3'b110: w_res = r_acc;
      3'b111: w_res = r_acc;
      default: w_res = r_acc;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_nx;
      if (r_state == S_IDLE) begin
        if (w_mul_go) begin
          r_mcand  <= w_a2;
          r_mplier <= w_b;
          r_prod   <= '0;
          r_cnt    <= '0;
        end else if (w_accept) begin
          r_acc <= w_res;
        end
      end else begin
        r_prod   <= w_prod_nx;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
        if (w_last) begin
          r_acc <= w_prod_nx;
        end
      end
    end
  end

  assign busy = (r_state == S_MUL);
  assign done = r_done;
  assign acc  = r_acc;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq (W=4): directed cases then random ops.
module tb_alu_acc_seq;

  localparam int W  = 4;
  localparam int AW = 2 * W;
  localparam int M  = 1 << AW;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [W-1:0]  A;
  logic [2:0]    op;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] acc;

  alu_acc_seq #(.W(W)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .A(A),
    .op(op),
    .start(start),
    .busy(busy),
    .done(done),
    .acc(acc)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int val;
    bit is_mul;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int total = 0;
  int bad = 0;
  int m_acc = 0;
  int hold_acc = 0;
  int run = 0;
  int last_run = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model straight from the operation table.
  function automatic int model(input int o, input int a, input int cur);
    int b;
    int s;
    b = cur % (1 << W);
    case (o)
      0: return (a + b) % M;
      1: begin
        s = cur + a;
`ifdef ALU_ACC_SAT_EN
        return (s > M - 1) ? M - 1 : s;
`else
        return s % M;
`endif
      end
      2: return ((a ^ b) << W) | (a | b);
      3: return ((a | b) != 0) ? (M / 2 + 1) : 0;
      4: return (a == (1 << W) - 1 && b == (1 << W) - 1) ? (M / 2 - 2) : 0;
      5: return (a >= AW) ? 0 : ((b << a) % M);
      6: return a * b;
      default: return cur;
    endcase
  endfunction

  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      run = 0;
    end else begin
      if (busy === 1'b1) begin
        run++;
        chk("mul_hold", int'(acc), hold_acc);
      end else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          chk("acc", int'(acc), e_mon.val);
          chk("busy_at_done", int'(busy), 0);
          if (e_mon.is_mul) chk("mul_busy_len", last_run, W);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge Clock);
      #2;
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input int o, input int a, input bit ign);
    exp_t e;
    wait_idle();
    e.is_mul = (o == 6);
    e.val = model(o, a, m_acc);
    if (e.is_mul) hold_acc = m_acc;
    sb.push_back(e);
    m_acc = e.val;
    op = 3'(o);
    A = W'(a);
    start = 1'b1;
    @(posedge Clock);
    #2;
    start = 1'b0;
    if (e.is_mul && ign) begin
      start = 1'b1;
      op = 3'b000;
      A = W'($urandom);
      @(posedge Clock);
      #2;
      start = 1'b0;
      op = 3'($urandom_range(0, 7));
      A = W'($urandom);
    end
  endtask

  task automatic set_acc(input int v);
    issue(4, 0, 1'b0);
    issue(0, v, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  initial begin
    int n;
    Reset = 1'b0;
    start = 1'b0;
    A = '0;
    op = '0;
    #12;
    Reset = 1'b1;
    #1;
    chk("rst_acc", int'(acc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge Clock);
    #2;
    Reset = 1'b0;

    set_acc(7);
    issue(0, 9, 1'b0);
    idle(3);

    set_acc(13);
    issue(6, 11, 1'b1);
    idle(6);

    set_acc(3);
    issue(5, 5, 1'b0);
    set_acc(3);
    issue(5, 9, 1'b0);
    issue(4, 0, 1'b0);
    issue(3, 0, 1'b0);
    set_acc(15);
    issue(4, 15, 1'b0);
    idle(2);

    issue(4, 0, 1'b0);
    issue(0, 15, 1'b0);
    issue(5, 4, 1'b0);
    issue(1, 12, 1'b0);
    issue(1, 7, 1'b0);
    idle(2);

    set_acc(9);
    issue(6, 7, 1'b0);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    chk("rst_mul_acc", int'(acc), 0);
    chk("rst_mul_busy", int'(busy), 0);
    chk("rst_mul_done", int'(done), 0);
    sb.delete();
    m_acc = 0;
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    idle(8);
    set_acc(5);
    issue(6, 3, 1'b0);
    idle(6);

    for (int i = 0; i < 300; i++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 15),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge Clock);
      n++;
    end
    chk("drain", sb.size(), 0);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Parametrised ALU with accumulator register; successor to the 4-bit lab ALU/register pair. An operand `A` from switches combines with the low half of the accumulator. Single-cycle ops write the accumulator on the accepting edge. Multiply runs as a sequential shift-add over `W` cycles with a start/busy/done handshake. The accumulator drives LEDs and hex decoders at top level.

## Interface
Parameters:
- `W`, default 4: operand width. The accumulator is `2W` bits wide.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `A`  in  W  data operand.
- `op`  in  3  operation select; sampled only on accept.
- `start`  in  1  request; accepted on an edge where `start=1` and `busy=0`.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse after any operation completes.
- `acc`  out  2W  accumulator. Operand `B` is defined as `acc[W-1:0]`.

## Operation
- Reset values: `acc=0`, `busy=0`, `done=0`, FSM=`IDLE`, iteration counter=0.
- FSM states:
  - `IDLE`: accepts a request.
    - Op `110` goes to `MUL`.
    - Any other op stays in `IDLE`.
  - `MUL`: returns to `IDLE` after `W` iterations.
- Ops. `A` and `B` are zero-extended to `2W` bits unless stated otherwise.
  - `000` add: `acc <= A + B`.
  - `001` accumulate: `acc <= acc + A`. Wraps modulo 2^(2W); see Configuration.
  - `010` logic: `acc <= {A^B, A|B}`.
  - `011` any-one: if `|{A,B}`, `acc` = MSB and LSB set, all other bits 0; else `acc = 0`.
  - `100` all-one: if `&{A,B}`, `acc` = MSB and LSB clear, all other bits 1; else `acc = 0`.
  - `101` shift: `acc <= B << A`, truncated to `2W` bits. `A >= 2W` gives 0.
  - `110` multiply: `acc <= A * B`, unsigned, exact in `2W` bits.
  - `111` hold: `acc` unchanged.
- Multiply datapath:
  - On accept, latch `A` into a multiplicand register and `B` into a multiplier register.
  - Clear an internal `2W`-bit product register.
  - Each `MUL` cycle: if the multiplier LSB is 1, add the shifted multiplicand to the product. Then shift the multiplicand left and the multiplier right.
  - `acc` holds its old value during `MUL` and is written only on the final iteration.
- A `start` seen while `busy=1` is ignored: not queued, with no effect on the operation in progress.
- `op` and `A` changes during `MUL` have no effect.

## Timing
- Single-cycle ops:
  - accept edge `E`: `acc` updated at `E`.
  - `done=1` for the cycle after `E`.
  - `busy` stays 0.
  - Back-to-back accepts on consecutive edges are legal; `done` then stays high continuously.
- Multiply:
  - accept edge `E`: `busy=1` from `E` to `E+W`.
  - `acc` written at `E+W`; `busy` falls at `E+W`; `done=1` for the cycle after `E+W`.
  - Latency is `W` cycles. A new `start` can be accepted at edge `E+W+1` or later.
- `Reset` asserted at any time, including mid-multiply, forces all reset values immediately. No partial product is written.
- The first accept is possible on the first rising edge after `Reset` deasserts.

## Configuration
- Macro `ALU_ACC_SAT_EN` controls overflow handling for op `001`.
- Defined: op `001` saturates. If `acc + A > 2^(2W)-1`, `acc <=` all ones.
- Undefined: op `001` wraps modulo 2^(2W).
- No other op is affected by this macro.

## Test plan
All scenarios use `W=4`.
- Reset: assert `Reset` mid-cycle -> `acc=0x00`, `busy=0`, `done=0` without waiting for a clock edge.
- Add: `acc=0x07`, `A=9`, `op=000`, `start` -> `acc=0x10` on the accept edge; `done` high exactly one cycle; `busy` never high.
- Multiply:
  - `acc=0x0D`, `A=11`, `op=110`, `start` -> `busy` high 4 cycles, `acc` stays `0x0D` throughout, then `acc=0x8F` and one `done` pulse.
  - A `start` with `op=000` pulsed during `busy` is ignored.
- Shift and reductions:
  - `B=3`, `A=5`, `op=101` -> `acc=0x60`.
  - `B=3`, `A=9`, `op=101` -> `acc=0x00`.
  - `A=0`, `B=0`, `op=011` -> `acc=0x00`.
  - `A=0xF`, `B=0xF`, `op=100` -> `acc=0x7E`.
- Accumulate overflow: `acc=0xFC`, `A=7`, `op=001` -> `acc=0xFF` with `ALU_ACC_SAT_EN` defined; `acc=0x03` without it.
- Reset mid-multiply: assert `Reset` on the 2nd busy cycle -> `acc=0x00`, `busy=0`, and no `done` pulse. After release, a multiply with `acc=0x05`, `A=3` -> `acc=0x0F` after 4 cycles.
